// File: rtl/msk_cst_arbiter.sv
// Round-robin arbiter sharing one public-constant serialiser between two requesters.
// Each granted word is emitted BW bits per beat as a bit-interleaved d-share sharing (x, 0, ..., 0).
module msk_cst_arbiter #(
    parameter int d  = 2,
    parameter int W  = 32,
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    in0_data,
    input  logic            in0_valid,
    output logic            in0_ready,
    input  logic [W-1:0]    in1_data,
    input  logic            in1_valid,
    output logic            in1_ready,
    output logic [BW*d-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_src,
    output logic            out_last,
    output logic            busy
);

    localparam int NBEAT = W / BW;
    localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q;
    logic [W-1:0]    word_q;
    logic            src_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            rr_q;
    logic [1:0]      reqValid;
    logic            grantValid;
    logic            grantIdx;
    logic            isLast;
    logic [BW-1:0]   chunk;

    assign reqValid = {in1_valid, in0_valid};
    assign cnt_d    = cnt_q + CW'(1);
    assign isLast   = (cnt_q == CW'(NBEAT - 1));
    assign chunk    = word_q[int'(cnt_q)*BW +: BW];

    // Grant prefers rr; readys are held low while reset is asserted.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = rr_q;
        if (state_q == IDLE && rst_n) begin
            if (reqValid[rr_q]) begin
                grantValid = 1'b1;
                grantIdx   = rr_q;
            end else if (reqValid[~rr_q]) begin
                grantValid = 1'b1;
                grantIdx   = ~rr_q;
            end
        end
    end

    assign in0_ready = grantValid && (grantIdx == 1'b0);
    assign in1_ready = grantValid && (grantIdx == 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            src_q   <= 1'b0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantValid) begin
                        word_q  <= grantIdx ? in1_data : in0_data;
                        src_q   <= grantIdx;
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (isLast) begin
                            state_q <= IDLE;
                            rr_q    <= ~src_q;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Share 0 of each bit carries the public value; the remaining shares stay zero.
    always_comb begin
        out_data = '0;
        if (state_q == SEND) begin
            for (int i = 0; i < BW; i++) begin
                out_data[i*d] = chunk[i];
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_src   = src_q;
    assign out_last  = (state_q == SEND) && isLast;

endmodule

// File: tb/tb_msk_cst_arbiter.sv
// Self-checking bench for msk_cst_arbiter: table-driven grants with a beat scoreboard,
// plus hand sequences for backpressure, mid-word reset and the d=1 / d=3 corner cases.
module tb_msk_cst_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in0Data = '0;
    logic        in0Valid = 1'b0;
    logic        in0Ready;
    logic [31:0] in1Data = '0;
    logic        in1Valid = 1'b0;
    logic        in1Ready;
    logic [15:0] outData;
    logic        outValid;
    logic        outReady = 1'b1;
    logic        outSrc;
    logic        outLast;
    logic        busy;

    logic [7:0]  sIn0Data = '0;
    logic        sIn0Valid = 1'b0;
    logic [7:0]  sIn1Data = '0;
    logic        sIn1Valid = 1'b0;
    logic        s1Ready0, s1Ready1, s1Valid, s1Src, s1Last, s1Busy;
    logic [7:0]  s1Data;
    logic        s3Ready0, s3Ready1, s3Valid, s3Src, s3Last, s3Busy;
    logic [23:0] s3Data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic        src;
        logic        last;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        logic        rstBefore;
        logic        v0;
        logic        v1;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        hold;
        logic        expSrc;
    } vec_t;
    vec_t vecs[10];

    msk_cst_arbiter #(.d(2), .W(32), .BW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_data(in0Data), .in0_valid(in0Valid), .in0_ready(in0Ready),
        .in1_data(in1Data), .in1_valid(in1Valid), .in1_ready(in1Ready),
        .out_data(outData), .out_valid(outValid), .out_ready(outReady),
        .out_src(outSrc), .out_last(outLast), .busy(busy)
    );

    msk_cst_arbiter #(.d(1), .W(8), .BW(8)) dutD1 (
        .clk(clk), .rst_n(rst_n),
        .in0_data(sIn0Data), .in0_valid(sIn0Valid), .in0_ready(s1Ready0),
        .in1_data(sIn1Data), .in1_valid(sIn1Valid), .in1_ready(s1Ready1),
        .out_data(s1Data), .out_valid(s1Valid), .out_ready(outReady),
        .out_src(s1Src), .out_last(s1Last), .busy(s1Busy)
    );

    msk_cst_arbiter #(.d(3), .W(8), .BW(8)) dutD3 (
        .clk(clk), .rst_n(rst_n),
        .in0_data(sIn0Data), .in0_valid(sIn0Valid), .in0_ready(s3Ready0),
        .in1_data(sIn1Data), .in1_valid(sIn1Valid), .in1_ready(s3Ready1),
        .out_data(s3Data), .out_valid(s3Valid), .out_ready(outReady),
        .out_src(s3Src), .out_last(s3Last), .busy(s3Busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] expand2(input logic [7:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[2*i] = b[i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushWord(input logic [31:0] w, input logic src);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.data = expand2(w[k*8 +: 8]);
            b.src  = src;
            b.last = (k == 3);
            sb.push_back(b);
        end
    endtask

    task automatic checkBeat(input string name);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: unexpected beat data 0x%0h, scoreboard empty", name, outData);
        end else begin
            checkOutput({name, ".data"}, 64'(outData), 64'(sb[0].data));
            checkOutput({name, ".src"},  64'(outSrc),  64'(sb[0].src));
            checkOutput({name, ".last"}, 64'(outLast), 64'(sb[0].last));
        end
    endtask

    task automatic drainBeats(input int budget);
        int cyc = 0;
        while (sb.size() > 0 && cyc < budget) begin
            if (outValid) begin
                checkOutput("sendReadysLow", 64'({in0Ready, in1Ready}), 64'(0));
                checkOutput("busyInSend", 64'(busy), 64'(1));
            end
            if (outValid && outReady) begin
                checkBeat("beat");
                void'(sb.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout: %0d beats outstanding, expected 0", sb.size());
            sb.delete();
        end
        checkOutput("idleBusy", 64'(busy), 64'(0));
        checkOutput("idleValid", 64'(outValid), 64'(0));
    endtask

    task automatic applyReset();
        rst_n    = 1'b0;
        in0Valid = 1'b1;
        in1Valid = 1'b1;
        #1;
        checkOutput("rstReady0", 64'(in0Ready), 64'(0));
        checkOutput("rstReady1", 64'(in1Ready), 64'(0));
        checkOutput("rstValid", 64'(outValid), 64'(0));
        checkOutput("rstBusy", 64'(busy), 64'(0));
        checkOutput("rstLast", 64'(outLast), 64'(0));
        checkOutput("rstData", 64'(outData), 64'(0));
        @(negedge clk);
        in0Valid = 1'b0;
        in1Valid = 1'b0;
        rst_n    = 1'b1;
        sb.delete();
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge after the word drains.
    task automatic applyStimulus(input vec_t v);
        in0Valid = v.v0;
        in0Data  = v.w0;
        in1Valid = v.v1;
        in1Data  = v.w1;
        #1;
        checkOutput("grantReady0", 64'(in0Ready), 64'(v.expSrc == 1'b0));
        checkOutput("grantReady1", 64'(in1Ready), 64'(v.expSrc == 1'b1));
        pushWord(v.expSrc ? v.w1 : v.w0, v.expSrc);
        @(negedge clk);
        if (!v.hold) begin
            in0Valid = 1'b0;
            in1Valid = 1'b0;
        end
        checkOutput("firstBeatLatency", 64'(outValid), 64'(1));
        drainBeats(40);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'hA1B2C3D4, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0, 32'h5A5A0F0F, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 32'h13579BDF, 1'b0, 1'b1};

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rstBefore) applyReset();
            applyStimulus(vecs[i]);
        end
        in0Valid = 1'b0;
        in1Valid = 1'b0;

        // Backpressure: stall beat 2 for five cycles.
        applyReset();
        in0Valid = 1'b1;
        in0Data  = 32'hDEADBEEF;
        pushWord(32'hDEADBEEF, 1'b0);
        @(negedge clk);
        in0Valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checkBeat("bpBeat");
            void'(sb.pop_front());
            @(negedge clk);
        end
        outReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bpValidHeld", 64'(outValid), 64'(1));
            checkBeat("bpStall");
            @(negedge clk);
        end
        outReady = 1'b1;
        drainBeats(10);

        // Mid-word reset: complete an in0 word so rr points at 1, then abort an in1 word.
        applyStimulus('{1'b0, 1'b1, 1'b0, 32'h76543210, 32'h0, 1'b0, 1'b0});
        in1Valid = 1'b1;
        in1Data  = 32'h0BADF00D;
        @(negedge clk);
        in1Valid = 1'b0;
        checkOutput("abortSrc", 64'(outSrc), 64'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncValidDrop", 64'(outValid), 64'(0));
        checkOutput("asyncBusyDrop", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("postRstQuiet", 64'(outValid), 64'(0));
        end
        applyStimulus('{1'b0, 1'b1, 1'b1, 32'h0F1E2D3C, 32'h4B5A6978, 1'b0, 1'b0});

        // Narrow instances: d=1 passes the raw byte, d=3 places bits at share 0 only.
        sIn0Valid = 1'b1;
        sIn0Data  = 8'h81;
        #1;
        checkOutput("d1Ready", 64'(s1Ready0), 64'(1));
        checkOutput("d3Ready", 64'(s3Ready0), 64'(1));
        @(negedge clk);
        sIn0Valid = 1'b0;
        checkOutput("d1Valid", 64'(s1Valid), 64'(1));
        checkOutput("d1Data", 64'(s1Data), 64'(8'h81));
        checkOutput("d1Last", 64'(s1Last), 64'(1));
        checkOutput("d1Src", 64'(s1Src), 64'(0));
        checkOutput("d3Data", 64'(s3Data), 64'(24'h200001));
        checkOutput("d3Last", 64'(s3Last), 64'(1));
        checkOutput("d3Busy", 64'(s3Busy), 64'(1));
        @(negedge clk);
        checkOutput("d1Done", 64'(s1Valid), 64'(0));
        checkOutput("d3Done", 64'(s3Valid), 64'(0));
        checkOutput("d1BusyDone", 64'(s1Busy), 64'(0));
        checkOutput("narrowIn1Idle", 64'({s1Ready1, s3Ready1, s3Src}), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
